mac_frame_driver: RTL and testbench

- Operand-side driver for the 8-bit Wallace/Kogge-Stone MAC.
- Accepts a stream of operand pairs over valid/ready and buffers them in a small FIFO.
- Groups pairs into frames: clears the MAC accumulator at frame start, feeds one pair per cycle, waits out MAC latency, then captures the final {cout,out} and returns it with a pair count over a valid/ready result port.

---
 rtl/mac_frame_driver.sv | 134 +++++++++++++
 tb/tb_mac_frame_driver.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mac_frame_driver.sv
// Operand-side frame driver for the 8-bit MAC: buffers operand pairs, feeds one per
// cycle between an accumulator clear and a latency drain, then returns {cout,out} and a pair count.
module mac_frame_driver #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned MAC_LATENCY = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [WIDTH-1:0]   s_a,
    input  logic [WIDTH-1:0]   s_b,
    input  logic               s_cin,
    input  logic               s_last,
    output logic [WIDTH-1:0]   mac_a,
    output logic [WIDTH-1:0]   mac_b,
    output logic               mac_cin,
    output logic               mac_clr,
    input  logic [2*WIDTH-1:0] mac_out,
    input  logic               mac_cout,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [2*WIDTH:0]   m_data,
    output logic [7:0]         m_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned EW = 2*WIDTH + 2;
    localparam int unsigned DW = (MAC_LATENCY > 0) ? $clog2(MAC_LATENCY + 1) : 1;

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, HOLD} state_t;

    state_t          state;
    logic [EW-1:0]   mem [DEPTH];
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic [EW-1:0]   head;
    logic [7:0]      frame_cnt;
    logic [DW-1:0]   drain_cnt;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign s_ready = !full;
    assign push    = s_valid && s_ready;
    assign pop     = (state == FEED) && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= {s_last, s_cin, s_b, s_a};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Frame sequencer; operand outputs default to a zero bubble every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mac_a     <= '0;
            mac_b     <= '0;
            mac_cin   <= 1'b0;
            mac_clr   <= 1'b0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_count   <= '0;
            frame_cnt <= '0;
            drain_cnt <= '0;
        end else begin
            mac_a   <= '0;
            mac_b   <= '0;
            mac_cin <= 1'b0;
            mac_clr <= 1'b0;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        mac_clr <= 1'b1;
                        state   <= CLEAR;
                    end
                end
                CLEAR: begin
                    frame_cnt <= '0;
                    state     <= FEED;
                end
                FEED: begin
                    if (!empty) begin
                        mac_a   <= head[WIDTH-1:0];
                        mac_b   <= head[2*WIDTH-1:WIDTH];
                        mac_cin <= head[2*WIDTH];
                        if (frame_cnt != 8'hFF)
                            frame_cnt <= frame_cnt + 8'd1;
                        if (head[EW-1]) begin
                            drain_cnt <= DW'(MAC_LATENCY);
                            state     <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        m_data  <= {mac_cout, mac_out};
                        m_count <= frame_cnt;
                        m_valid <= 1'b1;
                        state   <= HOLD;
                    end else begin
                        drain_cnt <= drain_cnt - DW'(1);
                    end
                end
                HOLD: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_frame_driver.sv
// Scoreboard bench for mac_frame_driver with a behavioural one-edge MAC attached.
module tb_mac_frame_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_a;
    logic [7:0]  s_b;
    logic        s_cin;
    logic        s_last;
    logic [7:0]  mac_a;
    logic [7:0]  mac_b;
    logic        mac_cin;
    logic        mac_clr;
    logic [15:0] mac_out;
    logic        mac_cout;
    logic        m_valid;
    logic        m_ready;
    logic [16:0] m_data;
    logic [7:0]  m_count;

    int n_checks = 0;
    int n_fail   = 0;
    int clr_cnt  = 0;
    int ld_cnt   = 0;
    int valid_seen = 0;
    logic [24:0] exp_q[$];

    mac_frame_driver dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b), .s_cin(s_cin), .s_last(s_last),
        .mac_a(mac_a), .mac_b(mac_b), .mac_cin(mac_cin), .mac_clr(mac_clr),
        .mac_out(mac_out), .mac_cout(mac_cout),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_count(m_count)
    );

    always #5 clk = ~clk;

    // MAC: out <= out + a*b + cin; all-zero operands leave out/cout untouched.
    always_ff @(posedge clk) begin
        if (mac_clr)
            {mac_cout, mac_out} <= 17'd0;
        else if (mac_a != 8'd0 || mac_b != 8'd0 || mac_cin)
            {mac_cout, mac_out} <= {1'b0, mac_out} + 17'(mac_a) * 17'(mac_b) + 17'(mac_cin);
    end

    initial {mac_cout, mac_out} = 17'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Result monitor and activity counters, sampled on the falling edge.
    always @(negedge clk) begin
        if (mac_clr) clr_cnt++;
        if (mac_a != 8'd0 || mac_b != 8'd0 || mac_cin) ld_cnt++;
        if (m_valid) valid_seen++;
        if (m_valid && m_ready && !rst) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'(m_data), 32'h1FFFF);
            end else begin
                logic [24:0] e;
                e = exp_q.pop_front();
                check("m_data", 32'(m_data), 32'(e[24:8]));
                check("m_count", 32'(m_count), 32'(e[7:0]));
            end
        end
    end

    // Called on a falling edge; returns on the falling edge after the push.
    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic last);
        int t = 0;
        s_valid = 1'b1; s_a = a; s_b = b; s_cin = cin; s_last = last;
        while (!s_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("s_ready_wait", 32'(s_ready), 32'd1);
        @(negedge clk);
        s_valid = 1'b0; s_a = '0; s_b = '0; s_cin = 1'b0; s_last = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int c0, l0, v0, t;
        rst = 1'b1; s_valid = 1'b0; s_a = '0; s_b = '0; s_cin = 1'b0; s_last = 1'b0; m_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_s_ready", 32'(s_ready), 32'd1);
        check("rst_mac_ops", 32'({mac_a, mac_b, mac_cin, mac_clr}), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'({m_data, m_count}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Contiguous five-pair frame
        c0 = clr_cnt; l0 = ld_cnt;
        exp_q.push_back({17'h15487, 8'd5});
        push(8'd15, 8'd10, 1'b0, 1'b0);
        push(8'd20, 8'd25, 1'b0, 1'b0);
        push(8'd50, 8'd30, 1'b0, 1'b0);
        push(8'd100, 8'd200, 1'b0, 1'b0);
        push(8'd255, 8'd255, 1'b0, 1'b1);
        wait_drain("t1_timeout");
        check("t1_clr_pulses", 32'(clr_cnt - c0), 32'd1);
        check("t1_loads", 32'(ld_cnt - l0), 32'd5);

        // Single-pair frame with carry-in
        exp_q.push_back({17'd13, 8'd1});
        push(8'd3, 8'd4, 1'b1, 1'b1);
        wait_drain("t2_timeout");

        // Same frame with two idle cycles between pairs
        c0 = clr_cnt; l0 = ld_cnt;
        exp_q.push_back({17'h15487, 8'd5});
        push(8'd15, 8'd10, 1'b0, 1'b0);  repeat (2) @(negedge clk);
        push(8'd20, 8'd25, 1'b0, 1'b0);  repeat (2) @(negedge clk);
        push(8'd50, 8'd30, 1'b0, 1'b0);  repeat (2) @(negedge clk);
        push(8'd100, 8'd200, 1'b0, 1'b0); repeat (2) @(negedge clk);
        push(8'd255, 8'd255, 1'b0, 1'b1);
        wait_drain("t3_timeout");
        check("t3_clr_pulses", 32'(clr_cnt - c0), 32'd1);
        check("t3_loads", 32'(ld_cnt - l0), 32'd5);

        // Result held back while the FIFO fills with the next frame
        @(posedge clk); #1 m_ready = 1'b0;
        @(negedge clk);
        exp_q.push_back({17'd1, 8'd1});
        push(8'd1, 8'd1, 1'b0, 1'b1);
        t = 0;
        while (!m_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("t4_m_valid_rise", 32'(m_valid), 32'd1);
        exp_q.push_back({17'd100, 8'd4});
        c0 = clr_cnt;
        for (int i = 0; i < 4; i++) begin
            push(8'(2*i + 1), 8'(2*i + 2), 1'b0, (i == 3));
            check("t4_hold", 32'({m_valid, m_data, m_count}), 32'({1'b1, 17'd1, 8'd1}));
        end
        check("t4_full_s_ready", 32'(s_ready), 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("t4_hold", 32'({m_valid, m_data, m_count}), 32'({1'b1, 17'd1, 8'd1}));
        end
        check("t4_no_clr_in_hold", 32'(clr_cnt - c0), 32'd0);
        @(posedge clk); #1 m_ready = 1'b1;
        @(negedge clk);
        wait_drain("t4_timeout");
        check("t4_clr_pulses", 32'(clr_cnt - c0), 32'd1);

        // Back-to-back single-pair frames
        c0 = clr_cnt;
        exp_q.push_back({17'd4, 8'd1});
        exp_q.push_back({17'd63, 8'd1});
        push(8'd2, 8'd2, 1'b0, 1'b1);
        push(8'd7, 8'd9, 1'b0, 1'b1);
        wait_drain("t5_timeout");
        check("t5_clr_pulses", 32'(clr_cnt - c0), 32'd2);

        // Reset while draining discards the frame
        push(8'd200, 8'd200, 1'b0, 1'b1);
        t = 0;
        while (mac_a != 8'd200 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("t6_load_seen", 32'(mac_a), 32'd200);
        @(negedge clk);
        v0 = valid_seen;
        rst = 1'b1;
        #1;
        check("t6_rst_s_ready", 32'(s_ready), 32'd1);
        check("t6_rst_mac_ops", 32'({mac_a, mac_b, mac_cin, mac_clr}), 32'd0);
        check("t6_rst_outputs", 32'({m_valid, m_data, m_count}), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("t6_no_result", 32'(valid_seen - v0), 32'd0);

        exp_q.push_back({17'd25, 8'd1});
        push(8'd5, 8'd5, 1'b0, 1'b1);
        wait_drain("t7_timeout");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
